fl_sink_responder: RTL and testbench
====================================

FL_SINK_RESPONDER -- requirements
Module: fl_sink_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning FrameLink data width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter DREM_WIDTH, default 3, meaning log2(DATA_WIDTH/8).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning nonzero reset value of the stall LFSR.
REQ-004 SHALL have port CLK  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port RX_DATA  in  DATA_WIDTH  FrameLink data; ignored except for width.
REQ-007 SHALL have port RX_REM  in  DREM_WIDTH  index of last valid byte in the EOP word.
REQ-008 SHALL have ports RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N  in  1 each  active-low frame/part delimiters.
REQ-009 SHALL have port RX_SRC_RDY_N  in  1  active-low source ready.
REQ-010 SHALL have port RX_DST_RDY_N  out  1  active-low destination ready, registered.
REQ-011 SHALL have port CFG_ENABLE  in  1  responder enable; 0 holds RX_DST_RDY_N high.
REQ-012 SHALL have port CFG_STALL_THRESH  in  8  stall threshold.
REQ-013 SHALL have port CNT_CLR  in  1  synchronous clear of counters and error status.
REQ-014 SHALL have port FRAME_CNT  out  32  completed frames.
REQ-015 SHALL have port BYTE_CNT  out  32  accepted bytes.
REQ-016 SHALL have port ERR_FLAG  out  1  sticky protocol error.
REQ-017 SHALL have port ERR_CODE  out  2  code of the first error: 0 NO_SOF, 1 DUP_SOF, 2 DUP_SOP_OR_NO_SOP, 3 EOF_NO_EOP.

Function
REQ-018 A transfer SHALL occur in a cycle where RX_SRC_RDY_N=0 and RX_DST_RDY_N=0; all other cycles SHALL leave the FSM and counters unchanged.
REQ-019 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting every cycle while CFG_ENABLE=1.
REQ-020 Next RX_DST_RDY_N SHALL be 0 iff CFG_ENABLE=1 and lfsr[7:0] >= CFG_STALL_THRESH; threshold 0 SHALL give permanent ready after one cycle.
REQ-021 The FSM SHALL have states IDLE (expect SOF+SOP), IN_PART (inside a part), GAP (between parts, expect SOP only).
REQ-022 From IDLE, a transfer with SOF_N=0 and SOP_N=0 SHALL go to IDLE if EOP_N=EOF_N=0, GAP if only EOP_N=0, else IN_PART.
REQ-023 From IN_PART, a transfer with EOP_N=0 and EOF_N=0 SHALL go to IDLE and increment FRAME_CNT; with only EOP_N=0 it SHALL go to GAP.
REQ-024 From GAP, a transfer with SOP_N=0 and SOF_N=1 SHALL go to IN_PART, or to IDLE/GAP per the EOP/EOF rule of REQ-023.
REQ-025 A single-word frame (all four delimiters 0 in IDLE) SHALL increment FRAME_CNT.
REQ-026 Errors SHALL be: NO_SOF (IDLE, SOF_N or SOP_N =1), DUP_SOF (IN_PART/GAP, SOF_N=0), DUP_SOP_OR_NO_SOP (IN_PART with SOP_N=0, or GAP with SOP_N=1), EOF_NO_EOP (EOF_N=0, EOP_N=1, any state).
REQ-027 On any error the FSM SHALL go to IDLE, FRAME_CNT SHALL NOT increment, ERR_FLAG SHALL set; ERR_CODE SHALL latch only when ERR_FLAG was 0; with multiple simultaneous errors the lowest code SHALL win.
REQ-028 BYTE_CNT SHALL add DATA_WIDTH/8 per non-EOP transfer and RX_REM+1 per EOP transfer, including erroneous words.
REQ-029 Counters SHALL wrap modulo 2^32 without flag.
REQ-030 CNT_CLR=1 SHALL zero FRAME_CNT, BYTE_CNT, ERR_FLAG, ERR_CODE on the next edge, overriding a same-cycle increment or error; FSM and LFSR SHALL be unaffected.
REQ-031 Counter and error outputs SHALL update one cycle after the transfer edge (registered).

Reset
REQ-032 RESET_N=0 SHALL asynchronously force RX_DST_RDY_N=1, FSM=IDLE, lfsr=LFSR_SEED, FRAME_CNT=0, BYTE_CNT=0, ERR_FLAG=0, ERR_CODE=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first post-reset transfer SHALL be checked from IDLE.

Verification
REQ-034 THRESH=0, ENABLE=1, one 3-word single-part frame, DATA_WIDTH=64, last REM=4 -> FRAME_CNT=1, BYTE_CNT=21, ERR_FLAG=0.
REQ-035 Two-part frame (parts of 2 words and 1 word, REM=7 on both EOPs) with SRC_RDY_N gaps -> FRAME_CNT=1, BYTE_CNT=24, no error.
REQ-036 Word with SOF_N=0 while IN_PART -> ERR_FLAG=1, ERR_CODE=1; following clean single-word frame -> FRAME_CNT=1, ERR_CODE stays 1.
REQ-037 THRESH=128 over 10000 cycles -> RX_DST_RDY_N=0 in 45-55% of cycles; ENABLE=0 -> RX_DST_RDY_N=1 within one cycle.
REQ-038 CNT_CLR asserted in the same cycle as a frame's EOF transfer -> FRAME_CNT=0, BYTE_CNT=0 next cycle; FSM in IDLE.
REQ-039 RESET_N pulsed low mid-frame, then a word with SOF_N=1 -> ERR_FLAG=1, ERR_CODE=0.

Source files
------------

// File: rtl/fl_sink_responder.sv
// -----------------------------------------------------------------------------
// fl_sink_responder
//
// FrameLink sink that accepts words, throttles the source with a pseudo-random
// destination-ready pattern and checks the SOF/SOP/EOP/EOF delimiter protocol.
// Counts completed frames and accepted bytes, and records the first protocol
// error seen.
//
// Ports
//   CLK, RESET_N          clock (rising edge) and asynchronous active-low reset
//   RX_DATA               FrameLink data (only its width matters)
//   RX_REM                index of the last valid byte in an EOP word
//   RX_SOF_N/SOP_N/EOP_N/EOF_N  active-low frame/part delimiters
//   RX_SRC_RDY_N          active-low source ready
//   RX_DST_RDY_N          active-low destination ready (registered)
//   CFG_ENABLE            responder enable; 0 keeps RX_DST_RDY_N high
//   CFG_STALL_THRESH      ready when lfsr[7:0] >= threshold
//   CNT_CLR               synchronous clear of counters and error status
//   FRAME_CNT, BYTE_CNT   completed frames / accepted bytes (wrap at 2^32)
//   ERR_FLAG, ERR_CODE    sticky error flag and code of the first error
// -----------------------------------------------------------------------------
module fl_sink_responder #(
    parameter int          DATA_WIDTH = 64,
    parameter int          DREM_WIDTH = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [DREM_WIDTH-1:0] RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    input  logic                  CFG_ENABLE,
    input  logic [7:0]            CFG_STALL_THRESH,
    input  logic                  CNT_CLR,
    output logic [31:0]           FRAME_CNT,
    output logic [31:0]           BYTE_CNT,
    output logic                  ERR_FLAG,
    output logic [1:0]            ERR_CODE
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // expecting SOF+SOP
        IN_PART = 2'd1,   // inside a part
        GAP     = 2'd2    // between parts, expecting SOP only
    } state_t;

    typedef enum logic [1:0] {
        ERR_NO_SOF     = 2'd0,
        ERR_DUP_SOF    = 2'd1,
        ERR_DUP_SOP    = 2'd2,
        ERR_EOF_NO_EOP = 2'd3
    } err_code_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        dst_rdy_n;
    logic [31:0] frame_cnt;
    logic [31:0] byte_cnt;
    logic        err_flag;
    err_code_t   err_code;

    logic        xfer;
    logic        err_no_sof;
    logic        err_dup_sof;
    logic        err_dup_sop;
    logic        err_eof_no_eop;
    logic        any_err;
    err_code_t   first_err;
    logic        frame_done;
    logic [31:0] word_bytes;

    // Payload content is irrelevant to this sink; reduce it so the port is used.
    logic rx_data_unused;
    assign rx_data_unused = ^RX_DATA;

    assign xfer    = !RX_SRC_RDY_N && !dst_rdy_n;
    // Fibonacci taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        next_state     = state;
        first_err      = ERR_NO_SOF;
        frame_done     = 1'b0;
        word_bytes     = 32'(BYTES_PER_WORD);

        err_no_sof     = (state == IDLE) && (RX_SOF_N || RX_SOP_N);
        err_dup_sof    = (state != IDLE) && !RX_SOF_N;
        err_dup_sop    = ((state == IN_PART) && !RX_SOP_N) || ((state == GAP) && RX_SOP_N);
        err_eof_no_eop = !RX_EOF_N && RX_EOP_N;
        any_err        = err_no_sof || err_dup_sof || err_dup_sop || err_eof_no_eop;

        // Lowest code wins when several errors hit the same word.
        if (err_no_sof)       first_err = ERR_NO_SOF;
        else if (err_dup_sof) first_err = ERR_DUP_SOF;
        else if (err_dup_sop) first_err = ERR_DUP_SOP;
        else                  first_err = ERR_EOF_NO_EOP;

        // Legal words share one successor rule in every state; errors resync to IDLE.
        if (any_err) begin
            next_state = IDLE;
        end else if (!RX_EOP_N && !RX_EOF_N) begin
            next_state = IDLE;
            frame_done = 1'b1;
        end else if (!RX_EOP_N) begin
            next_state = GAP;
        end else begin
            next_state = IN_PART;
        end

        if (!RX_EOP_N) word_bytes = 32'(RX_REM) + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            dst_rdy_n <= 1'b1;
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_flag  <= 1'b0;
            err_code  <= ERR_NO_SOF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (CFG_ENABLE) lfsr <= {lfsr[14:0], lfsr_fb};
            dst_rdy_n <= !(CFG_ENABLE && (lfsr[7:0] >= CFG_STALL_THRESH));

            if (xfer) state <= next_state;

            // Clear takes priority over anything the same word would record.
            if (CNT_CLR) begin
                frame_cnt <= '0;
                byte_cnt  <= '0;
                err_flag  <= 1'b0;
                err_code  <= ERR_NO_SOF;
            end else if (xfer) begin
                byte_cnt <= byte_cnt + word_bytes;
                if (frame_done) frame_cnt <= frame_cnt + 32'd1;
                if (any_err) begin
                    err_flag <= 1'b1;
                    if (!err_flag) err_code <= first_err;
                end
            end
        end
    end

    assign RX_DST_RDY_N = dst_rdy_n;
    assign FRAME_CNT    = frame_cnt;
    assign BYTE_CNT     = byte_cnt;
    assign ERR_FLAG     = err_flag;
    assign ERR_CODE     = err_code;

endmodule

// File: tb/tb_fl_sink_responder.sv
// -----------------------------------------------------------------------------
// tb_fl_sink_responder
//
// Directed bench for fl_sink_responder (DATA_WIDTH=64). Each task drives one
// scenario and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fl_sink_responder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [63:0] RX_DATA;
    logic [2:0]  RX_REM;
    logic        RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N;
    logic        RX_SRC_RDY_N;
    logic        RX_DST_RDY_N;
    logic        CFG_ENABLE;
    logic [7:0]  CFG_STALL_THRESH;
    logic        CNT_CLR;
    logic [31:0] FRAME_CNT;
    logic [31:0] BYTE_CNT;
    logic        ERR_FLAG;
    logic [1:0]  ERR_CODE;

    int n_tests = 0;
    int n_fail  = 0;

    fl_sink_responder dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .RX_DATA          (RX_DATA),
        .RX_REM           (RX_REM),
        .RX_SOF_N         (RX_SOF_N),
        .RX_SOP_N         (RX_SOP_N),
        .RX_EOP_N         (RX_EOP_N),
        .RX_EOF_N         (RX_EOF_N),
        .RX_SRC_RDY_N     (RX_SRC_RDY_N),
        .RX_DST_RDY_N     (RX_DST_RDY_N),
        .CFG_ENABLE       (CFG_ENABLE),
        .CFG_STALL_THRESH (CFG_STALL_THRESH),
        .CNT_CLR          (CNT_CLR),
        .FRAME_CNT        (FRAME_CNT),
        .BYTE_CNT         (BYTE_CNT),
        .ERR_FLAG         (ERR_FLAG),
        .ERR_CODE         (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic idle_bus();
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1; RX_EOF_N = 1'b1;
        RX_REM = 3'd0;
        CNT_CLR = 1'b0;
    endtask

    // Present one word and hold it until it is accepted (bounded wait).
    task automatic send_word(input logic sof_n, input logic sop_n, input logic eop_n,
                             input logic eof_n, input logic [2:0] rem, input logic clr);
        int  waited = 0;
        bit  done   = 0;
        RX_SOF_N = sof_n; RX_SOP_N = sop_n; RX_EOP_N = eop_n; RX_EOF_N = eof_n;
        RX_REM = rem; CNT_CLR = clr;
        RX_DATA = {$urandom, $urandom};
        RX_SRC_RDY_N = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (RX_DST_RDY_N === 1'b0) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 1000) begin
                    n_tests++; n_fail++;
                    $display("FAIL send_word_timeout: dst_rdy_n=%b after %0d cycles, required 0", RX_DST_RDY_N, waited);
                    done = 1;
                end
            end
        end
        @(posedge CLK); #1;
        idle_bus();
    endtask

    // Idle cycles with delimiters asserted but source not ready: must be ignored.
    task automatic gap_cycles(input int n);
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N = 1'b0; RX_SOP_N = 1'b0; RX_EOP_N = 1'b0; RX_EOF_N = 1'b0; RX_REM = 3'd7;
        repeat (n) @(posedge CLK);
        #1;
        idle_bus();
    endtask

    task automatic clear_counters();
        CNT_CLR = 1'b1;
        @(posedge CLK); #1;
        CNT_CLR = 1'b0;
    endtask

    task automatic do_reset(input logic enable, input logic [7:0] thresh);
        CFG_ENABLE = enable; CFG_STALL_THRESH = thresh;
        idle_bus();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 8'd0);
        n_tests++; if (RX_DST_RDY_N !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", RX_DST_RDY_N); end
        n_tests++; if (FRAME_CNT !== 32'd0) begin n_fail++; $display("FAIL reset_frame: got %0d want 0", FRAME_CNT); end
        n_tests++; if (BYTE_CNT !== 32'd0) begin n_fail++; $display("FAIL reset_bytes: got %0d want 0", BYTE_CNT); end
        n_tests++; if (ERR_FLAG !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag: got %b want 0", ERR_FLAG); end
        n_tests++; if (ERR_CODE !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", ERR_CODE); end
        @(posedge CLK); #1;
        n_tests++; if (RX_DST_RDY_N !== 1'b0) begin n_fail++; $display("FAIL thresh0_rdy: got %b want 0", RX_DST_RDY_N); end
    endtask

    // 3-word single-part frame: 8 + 8 + (4+1) = 21 bytes.
    task automatic test_single_part();
        send_word(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        send_word(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        send_word(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
        n_tests++; if (FRAME_CNT !== 32'd1) begin n_fail++; $display("FAIL single_frame: got %0d want 1", FRAME_CNT); end
        n_tests++; if (BYTE_CNT !== 32'd21) begin n_fail++; $display("FAIL single_bytes: got %0d want 21", BYTE_CNT); end
        n_tests++; if (ERR_FLAG !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", ERR_FLAG); end
    endtask

    // Parts of 2 words and 1 word, REM=7 on both EOPs, source gaps between words.
    task automatic test_two_part();
        clear_counters();
        n_tests++; if (FRAME_CNT !== 32'd0 || BYTE_CNT !== 32'd0) begin n_fail++; $display("FAIL clr_counts: got %0d/%0d want 0/0", FRAME_CNT, BYTE_CNT); end
        send_word(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        gap_cycles(2);
        send_word(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
        n_tests++; if (FRAME_CNT !== 32'd0 || BYTE_CNT !== 32'd16) begin n_fail++; $display("FAIL part1_counts: got %0d/%0d want 0/16", FRAME_CNT, BYTE_CNT); end
        gap_cycles(3);
        send_word(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0);
        n_tests++; if (FRAME_CNT !== 32'd1) begin n_fail++; $display("FAIL two_part_frame: got %0d want 1", FRAME_CNT); end
        n_tests++; if (BYTE_CNT !== 32'd24) begin n_fail++; $display("FAIL two_part_bytes: got %0d want 24", BYTE_CNT); end
        n_tests++; if (ERR_FLAG !== 1'b0) begin n_fail++; $display("FAIL two_part_err: got %b want 0", ERR_FLAG); end
    endtask

    task automatic test_dup_sof();
        clear_counters();
        send_word(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        send_word(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd1) begin n_fail++; $display("FAIL dup_sof_err: got flag=%b code=%0d want 1/1", ERR_FLAG, ERR_CODE); end
        n_tests++; if (FRAME_CNT !== 32'd0 || BYTE_CNT !== 32'd16) begin n_fail++; $display("FAIL dup_sof_counts: got %0d/%0d want 0/16", FRAME_CNT, BYTE_CNT); end
        send_word(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
        n_tests++; if (FRAME_CNT !== 32'd1 || BYTE_CNT !== 32'd20) begin n_fail++; $display("FAIL after_err_frame: got %0d/%0d want 1/20", FRAME_CNT, BYTE_CNT); end
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd1) begin n_fail++; $display("FAIL err_sticky: got flag=%b code=%0d want 1/1", ERR_FLAG, ERR_CODE); end
    endtask

    task automatic test_error_codes();
        // IDLE word with SOF_N=1 and EOF without EOP: codes 0 and 3, lowest wins.
        clear_counters();
        n_tests++; if (ERR_FLAG !== 1'b0 || ERR_CODE !== 2'd0) begin n_fail++; $display("FAIL clr_err: got flag=%b code=%0d want 0/0", ERR_FLAG, ERR_CODE); end
        send_word(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd0) begin n_fail++; $display("FAIL prio_0_3: got flag=%b code=%0d want 1/0", ERR_FLAG, ERR_CODE); end
        // A later EOF_NO_EOP must not overwrite the first code.
        send_word(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        n_tests++; if (ERR_CODE !== 2'd0 || BYTE_CNT !== 32'd16 || FRAME_CNT !== 32'd0) begin n_fail++; $display("FAIL first_code_kept: got code=%0d bytes=%0d frames=%0d want 0/16/0", ERR_CODE, BYTE_CNT, FRAME_CNT); end
        // SOP inside a part.
        clear_counters();
        send_word(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        send_word(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd2) begin n_fail++; $display("FAIL dup_sop: got flag=%b code=%0d want 1/2", ERR_FLAG, ERR_CODE); end
        // In GAP: SOF_N=0 with SOP_N=1 -> codes 1 and 2, lowest wins.
        clear_counters();
        send_word(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        send_word(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd1) begin n_fail++; $display("FAIL gap_prio_1_2: got flag=%b code=%0d want 1/1", ERR_FLAG, ERR_CODE); end
        // In GAP: plain data word without SOP.
        clear_counters();
        send_word(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        send_word(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd2) begin n_fail++; $display("FAIL gap_no_sop: got flag=%b code=%0d want 1/2", ERR_FLAG, ERR_CODE); end
        // EOF without EOP on an otherwise valid IDLE word.
        clear_counters();
        send_word(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd3 || FRAME_CNT !== 32'd0) begin n_fail++; $display("FAIL eof_no_eop: got flag=%b code=%0d frames=%0d want 1/3/0", ERR_FLAG, ERR_CODE, FRAME_CNT); end
    endtask

    task automatic test_clr_same_cycle();
        clear_counters();
        send_word(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        send_word(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
        n_tests++; if (FRAME_CNT !== 32'd0 || BYTE_CNT !== 32'd0) begin n_fail++; $display("FAIL clr_override: got %0d/%0d want 0/0", FRAME_CNT, BYTE_CNT); end
        // FSM must be back in IDLE: a clean single-word frame is accepted.
        send_word(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        n_tests++; if (FRAME_CNT !== 32'd1 || BYTE_CNT !== 32'd1 || ERR_FLAG !== 1'b0) begin n_fail++; $display("FAIL clr_then_frame: got %0d/%0d err=%b want 1/1/0", FRAME_CNT, BYTE_CNT, ERR_FLAG); end
    endtask

    task automatic test_stall();
        logic [15:0] m_lfsr;
        logic        exp_rdy_n;
        int          n_ready  = 0;
        int          n_mis    = 0;
        do_reset(1'b0, 8'd128);
        m_lfsr = 16'hACE1;
        CFG_ENABLE = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(posedge CLK); #1;
            exp_rdy_n = (m_lfsr[7:0] >= 8'd128) ? 1'b0 : 1'b1;
            m_lfsr = lfsr_next(m_lfsr);
            if (RX_DST_RDY_N !== exp_rdy_n) begin
                if (n_mis == 0) $display("FAIL stall_pattern: cycle %0d got %b want %b", i, RX_DST_RDY_N, exp_rdy_n);
                n_mis++;
            end
            if (RX_DST_RDY_N === 1'b0) n_ready++;
        end
        n_tests++; if (n_mis != 0) begin n_fail++; $display("FAIL stall_pattern_total: %0d mismatching cycles, want 0", n_mis); end
        n_tests++; if (n_ready < 4500 || n_ready > 5500) begin n_fail++; $display("FAIL stall_ratio: ready %0d of 10000, want 4500..5500", n_ready); end
        CFG_ENABLE = 1'b0;
        @(posedge CLK); #1;
        n_tests++; if (RX_DST_RDY_N !== 1'b1) begin n_fail++; $display("FAIL disable_rdy: got %b want 1", RX_DST_RDY_N); end
        repeat (3) @(posedge CLK);
        #1;
        n_tests++; if (RX_DST_RDY_N !== 1'b1) begin n_fail++; $display("FAIL disable_hold: got %b want 1", RX_DST_RDY_N); end
    endtask

    task automatic test_reset_mid_frame();
        CFG_ENABLE = 1'b1; CFG_STALL_THRESH = 8'd0;
        send_word(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        #3;
        RESET_N = 1'b0;
        #1;
        n_tests++; if (RX_DST_RDY_N !== 1'b1 || BYTE_CNT !== 32'd0) begin n_fail++; $display("FAIL async_reset: got rdy=%b bytes=%0d want 1/0", RX_DST_RDY_N, BYTE_CNT); end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        // FSM restarted in IDLE, so a word without SOF is NO_SOF (code 0).
        send_word(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        n_tests++; if (ERR_FLAG !== 1'b1 || ERR_CODE !== 2'd0) begin n_fail++; $display("FAIL post_reset_err: got flag=%b code=%0d want 1/0", ERR_FLAG, ERR_CODE); end
        n_tests++; if (BYTE_CNT !== 32'd8 || FRAME_CNT !== 32'd0) begin n_fail++; $display("FAIL post_reset_counts: got %0d/%0d want 8/0", BYTE_CNT, FRAME_CNT); end
    endtask

    initial begin
        RESET_N = 1'b0;
        RX_DATA = '0;
        CFG_ENABLE = 1'b0;
        CFG_STALL_THRESH = 8'd0;
        idle_bus();
        test_reset();
        test_single_part();
        test_two_part();
        test_dup_sof();
        test_error_codes();
        test_clr_same_cycle();
        test_stall();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
